// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice walks the operands LSB first,
// publishing {cout, sum} after WIDTH RUN cycles with abort and back-to-back start.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  // One-hot so busy/done are single state flops.
  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StRun  = 3'b010,
    StDone = 3'b100
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             bit_a;
  logic             bit_b;
  logic             bit_s;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             last_bit;

  always_comb begin
    bit_a     = a_q[0];
    bit_b     = b_q[0];
    bit_s     = bit_a ^ bit_b ^ carry_q;
    carry_nxt = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
    // Result enters at the MSB so after WIDTH shifts bit 0 holds the first sum bit.
    res_nxt   = {bit_s, res_q[WIDTH-1:1]};
    last_bit  = (cnt_q == CntLast);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // Start beats abort here; abort only matters while running.
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            res_q   <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            res_q   <= res_nxt;
            carry_q <= carry_nxt;
            if (last_bit) begin
              sum_q   <= res_nxt;
              cout_q  <= carry_nxt;
              state_q <= StDone;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

`ifndef SYNTHESIS
  a_state_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot(state_q));
  a_cnt_range:    assert property (@(posedge clk) disable iff (!rstn) cnt_q <= CntLast);
  a_busy_done:    assert property (@(posedge clk) disable iff (!rstn) !(busy && done));
`endif

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request a new addition; sampled only when accepted (REQ-013).
REQ-005 SHALL have port abort  input  1  cancel the addition in progress.
REQ-006 SHALL have port op_a  input  WIDTH  first operand, captured on accepted start.
REQ-007 SHALL have port op_b  input  WIDTH  second operand, captured on accepted start.
REQ-008 SHALL have port cin  input  1  initial carry, captured on accepted start.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port sum  output  WIDTH  registered result of the last completed addition.
REQ-012 SHALL have port cout  output  1  registered carry-out of the last completed addition.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; start SHALL be accepted in IDLE or DONE, and in RUN it SHALL be ignored.
REQ-014 On an accepted start edge, SHALL load op_a/op_b into internal shift registers, load cin into the carry flop, clear bit counter to 0, and go to RUN.
REQ-015 Each RUN edge SHALL compute one bit through an internal 1-bit full-adder slice, LSB first: s = a[i] ^ b[i] ^ c, c_next = a[i]&b[i] | c&(a[i]^b[i]).
REQ-016 Each RUN edge SHALL shift s into an internal result shift register, update the carry flop with c_next and increment the counter.
REQ-017 On the RUN edge where the counter equals WIDTH-1, SHALL load sum from the completed shift register, load cout from c_next, and go to DONE.
REQ-018 Latency: with start accepted at edge k, done SHALL be high for exactly the cycle following edge k+WIDTH.
REQ-019 DONE SHALL last one cycle, going to IDLE, or to RUN if start is high.
REQ-020 Back-to-back starts SHALL therefore give one done pulse every WIDTH+1 cycles.
REQ-021 sum and cout SHALL change only on the completion edge and hold their value until the next completion.
REQ-022 abort high on a RUN edge SHALL return to IDLE without a done pulse and SHALL leave sum/cout unchanged.
REQ-023 abort in IDLE or DONE SHALL have no effect.
REQ-024 If abort and start are both high in DONE, start SHALL win.
REQ-025 The counter SHALL be sized ceil(log2(WIDTH)) bits and SHALL never wrap past WIDTH-1 in RUN.
REQ-026 busy SHALL be 1 only in RUN and done SHALL be 1 only in DONE, both decoded directly from state flops.

Reset
REQ-027 rstn low SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0 and shift registers=0.
REQ-028 Reset asserted mid-RUN SHALL discard the operation with no done pulse.
REQ-029 After rstn deasserts, the first start SHALL be accepted on the first rising edge at which rstn is high.

Verification
REQ-030 WIDTH=8: op_a=0x0F, op_b=0x01, cin=0, start 1 cycle -> busy 8 cycles, done pulse at edge+8, sum=0x10, cout=0.
REQ-031 WIDTH=8: op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1; then op_a=0xFF, op_b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-032 start held high continuously with op_a=0x55, op_b=0xAA, cin=0 -> done every 9 cycles, sum=0xFF, cout=0; start pulses during RUN ignored, operands unchanged mid-run.
REQ-033 Complete 0x03+0x04 (sum=0x07), then start 0x80+0x80 and abort at the 4th RUN edge -> IDLE, no done, sum=0x07, cout=0 retained.
REQ-034 rstn pulsed low mid-RUN -> all outputs 0 asynchronously, no done; next start 0x01+0x01 -> sum=0x02 with normal latency.
REQ-035 Bench SHALL run a random sweep (>=1000 ops, WIDTH=8 and WIDTH=3) against a scoreboard computing {cout,sum} = op_a+op_b+cin.
